demux_lane_scheduler: RTL and testbench

//  Sequences the 1x4 8-bit byte demultiplexer of the PCIe PHY datapath: steers each valid input byte

---
 rtl/demux_lane_scheduler.sv | 210 +++++++++++++++++++++
 tb/tb_demux_lane_scheduler.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/demux_lane_scheduler.sv
// demux_lane_scheduler: steers valid input bytes round-robin onto 1, 2 or 4
// active lanes, honouring per-lane ready. A requested lane count is held as
// pending until the stripe pointer is back at lane 0, and only then applied.
// A watchdog raises a sticky err_timeout when a stall lasts too long. It only
// reports the condition and never blocks traffic.
// Optional feature: define STRIPE_COUNT_EN to add the stripe_cnt output, which
// counts completed stripes.
module demux_lane_scheduler #(
  parameter logic [1:0] DEFAULT_CFG = 2'b10,
  parameter int         STALL_MAX   = 16,
  parameter int         CNT_W       = 8
) (
  input  logic             clk,
  input  logic             reset_L,
  input  logic             validIn,
  input  logic [7:0]       In,
  input  logic             ready0,
  input  logic             ready1,
  input  logic             ready2,
  input  logic             ready3,
  input  logic [1:0]       lane_cfg,
  input  logic             cfg_load,
  output logic             inReady,
  output logic [1:0]       sel,
  output logic             outValid0,
  output logic             outValid1,
  output logic             outValid2,
  output logic             outValid3,
  output logic [7:0]       data_out0,
  output logic [7:0]       data_out1,
  output logic [7:0]       data_out2,
  output logic [7:0]       data_out3,
  output logic [1:0]       cfg_active,
`ifdef STRIPE_COUNT_EN
  output logic [CNT_W-1:0] stripe_cnt,
`endif
  output logic             err_timeout
);

  localparam int SC_W = $clog2(STALL_MAX + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_STALL = 2'd2;

  // Index of the last active lane for a lane configuration.
  function automatic logic [1:0] last_lane(input logic [1:0] cfg);
    logic [1:0] r;
    case (cfg)
      2'b00:   r = 2'd0;
      2'b01:   r = 2'd1;
      default: r = 2'd3;
    endcase
    return r;
  endfunction

  logic [1:0]      ptr_q, ptr_d;
  logic [1:0]      state_q, state_d;
  logic [SC_W-1:0] stall_cnt_q, stall_cnt_d;
  logic            err_q, err_d;
  logic [1:0]      pending_q, pending_d;
  logic            pending_v_q, pending_v_d;
  logic [1:0]      cfg_active_q, cfg_active_d;
  logic [3:0]      out_valid_q, out_valid_d;
  logic [3:0][7:0] data_q, data_d;
  logic [1:0]      sel_q, sel_d;
`ifdef STRIPE_COUNT_EN
  logic [CNT_W-1:0] stripe_cnt_q, stripe_cnt_d;
`endif

  logic [3:0] ready_vec_s;
  logic       ready_sel_s;
  logic       accept_s;
  logic       pend_eff_v_s;
  logic [1:0] pend_eff_s;
  logic       apply_s;
  logic [1:0] cfg_now_s;
  logic       wrap_s;

  // Handshake and config-apply decode. A config loaded this cycle takes
  // precedence over an older pending one. The apply happens at the stripe
  // boundary (ptr at lane 0), so an accept in the same cycle already uses the
  // new lane count when it computes the next pointer.
  always_comb begin
    ready_vec_s  = {ready3, ready2, ready1, ready0};
    ready_sel_s  = ready_vec_s[ptr_q];
    accept_s     = validIn & ready_sel_s;
    pend_eff_v_s = cfg_load | pending_v_q;
    pend_eff_s   = cfg_load ? lane_cfg : pending_q;
    apply_s      = pend_eff_v_s & (ptr_q == 2'd0);
    cfg_now_s    = apply_s ? pend_eff_s : cfg_active_q;
    wrap_s       = (ptr_q == last_lane(cfg_now_s));
  end

  // Datapath next state: pointer, lane valids and data, sel, and config.
  always_comb begin
    ptr_d        = ptr_q;
    out_valid_d  = 4'b0000;
    data_d       = data_q;
    sel_d        = sel_q;
    cfg_active_d = cfg_now_s;
    pending_d    = pend_eff_s;
    if (apply_s) begin
      pending_v_d = 1'b0;
    end else begin
      pending_v_d = pend_eff_v_s;
    end
    if (accept_s) begin
      out_valid_d[ptr_q] = 1'b1;
      data_d[ptr_q]      = In;
      sel_d              = ptr_q;
      if (wrap_s) begin
        ptr_d = 2'd0;
      end else begin
        ptr_d = ptr_q + 2'd1;
      end
    end else begin
      ptr_d = ptr_q;
    end
  end

  // Flow FSM and stall watchdog. The counter only advances while already in
  // STALL, clears on any accept or dropped valid, and saturates.
  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) state_d = ST_RUN;
        else          state_d = ST_IDLE;
      end
      ST_RUN: begin
        if (validIn && !ready_sel_s) state_d = ST_STALL;
        else                         state_d = ST_RUN;
      end
      ST_STALL: begin
        if (accept_s || !validIn) state_d = ST_RUN;
        else                      state_d = ST_STALL;
      end
      default: state_d = ST_IDLE;
    endcase
    if (accept_s || !validIn) begin
      stall_cnt_d = {SC_W{1'b0}};
    end else if ((state_q == ST_STALL) && (stall_cnt_q != SC_W'(STALL_MAX))) begin
      stall_cnt_d = stall_cnt_q + SC_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
    err_d = err_q | (stall_cnt_q == SC_W'(STALL_MAX));
  end

`ifdef STRIPE_COUNT_EN
  // Completed-stripe counter: bumps on the accept that wraps the pointer.
  always_comb begin
    if (accept_s && wrap_s) stripe_cnt_d = stripe_cnt_q + CNT_W'(1);
    else                    stripe_cnt_d = stripe_cnt_q;
  end
`endif

  // State registers with synchronous active-low reset. Reset discards any
  // partial stripe and any pending config.
  always_ff @(posedge clk) begin
    if (!reset_L) begin
      ptr_q        <= 2'd0;
      state_q      <= ST_IDLE;
      stall_cnt_q  <= {SC_W{1'b0}};
      err_q        <= 1'b0;
      pending_q    <= 2'b00;
      pending_v_q  <= 1'b0;
      cfg_active_q <= DEFAULT_CFG;
      out_valid_q  <= 4'b0000;
      data_q       <= '0;
      sel_q        <= 2'd0;
`ifdef STRIPE_COUNT_EN
      stripe_cnt_q <= {CNT_W{1'b0}};
`endif
    end else begin
      ptr_q        <= ptr_d;
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      err_q        <= err_d;
      pending_q    <= pending_d;
      pending_v_q  <= pending_v_d;
      cfg_active_q <= cfg_active_d;
      out_valid_q  <= out_valid_d;
      data_q       <= data_d;
      sel_q        <= sel_d;
`ifdef STRIPE_COUNT_EN
      stripe_cnt_q <= stripe_cnt_d;
`endif
    end
  end

  assign inReady     = ready_sel_s;
  assign sel         = sel_q;
  assign outValid0   = out_valid_q[0];
  assign outValid1   = out_valid_q[1];
  assign outValid2   = out_valid_q[2];
  assign outValid3   = out_valid_q[3];
  assign data_out0   = data_q[0];
  assign data_out1   = data_q[1];
  assign data_out2   = data_q[2];
  assign data_out3   = data_q[3];
  assign cfg_active  = cfg_active_q;
  assign err_timeout = err_q;
`ifdef STRIPE_COUNT_EN
  assign stripe_cnt  = stripe_cnt_q;
`endif

endmodule

// File: tb/tb_demux_lane_scheduler.sv
// Bench for demux_lane_scheduler: directed scenarios plus randomized traffic,
// checked each cycle against a lane/stripe reference model.
module tb_demux_lane_scheduler;

  localparam int STALL_MAX = 16;

  logic       clk;
  logic       reset_L;
  logic       validIn;
  logic [7:0] in_byte;
  logic [3:0] rdy;
  logic [1:0] lane_cfg;
  logic       cfg_load;
  logic       inReady;
  logic [1:0] sel;
  logic       ov0, ov1, ov2, ov3;
  logic [7:0] d0, d1, d2, d3;
  logic [1:0] cfg_active;
  logic       err_timeout;
`ifdef STRIPE_COUNT_EN
  logic [7:0] stripe_cnt;
`endif

  demux_lane_scheduler dut (
    .clk(clk), .reset_L(reset_L), .validIn(validIn), .In(in_byte),
    .ready0(rdy[0]), .ready1(rdy[1]), .ready2(rdy[2]), .ready3(rdy[3]),
    .lane_cfg(lane_cfg), .cfg_load(cfg_load), .inReady(inReady), .sel(sel),
    .outValid0(ov0), .outValid1(ov1), .outValid2(ov2), .outValid3(ov3),
    .data_out0(d0), .data_out1(d1), .data_out2(d2), .data_out3(d3),
    .cfg_active(cfg_active),
`ifdef STRIPE_COUNT_EN
    .stripe_cnt(stripe_cnt),
`endif
    .err_timeout(err_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  int         m_ptr;
  logic [1:0] m_cfg;
  logic [1:0] m_pend;
  logic       m_pend_v;
  logic [7:0] m_data [4];
  int         m_sel;
  int         m_stallrun;
  logic       m_err;
  int         m_stripes;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int nlanes(input logic [1:0] c);
    if (c == 2'b00) return 1;
    else if (c == 2'b01) return 2;
    else return 4;
  endfunction

  task automatic model_reset();
    m_ptr = 0; m_cfg = 2'b10; m_pend = 2'b00; m_pend_v = 1'b0;
    for (int i = 0; i < 4; i++) m_data[i] = 8'h00;
    m_sel = 0; m_stallrun = 0; m_err = 1'b0; m_stripes = 0;
  endtask

  // One clock of stimulus with model update and output comparison.
  task automatic cycle(input logic v, input logic [7:0] d, input logic [3:0] r,
                       input logic cl, input logic [1:0] c);
    logic [3:0] exp_valid;
    logic       acc;
    @(negedge clk);
    validIn = v; in_byte = d; rdy = r; cfg_load = cl; lane_cfg = c;
    #1;
    if (v) chk("inReady", {31'd0, inReady}, {31'd0, r[m_ptr]});
    if (cl) begin m_pend = c; m_pend_v = 1'b1; end
    if (m_pend_v && m_ptr == 0) begin m_cfg = m_pend; m_pend_v = 1'b0; end
    acc = v && r[m_ptr];
    exp_valid = 4'b0000;
    if (acc) begin
      exp_valid[m_ptr] = 1'b1;
      m_data[m_ptr] = d;
      m_sel = m_ptr;
      if ((m_ptr + 1) % nlanes(m_cfg) == 0) m_stripes++;
      m_ptr = (m_ptr + 1) % nlanes(m_cfg);
    end
    if (v && !r[m_ptr] && !acc) m_stallrun++;
    else m_stallrun = 0;
    if (m_stallrun >= STALL_MAX + 2) m_err = 1'b1;
    @(posedge clk);
    #1;
    chk("outValid", {28'd0, ov3, ov2, ov1, ov0}, {28'd0, exp_valid});
    chk("data0", {24'd0, d0}, {24'd0, m_data[0]});
    chk("data1", {24'd0, d1}, {24'd0, m_data[1]});
    chk("data2", {24'd0, d2}, {24'd0, m_data[2]});
    chk("data3", {24'd0, d3}, {24'd0, m_data[3]});
    if (exp_valid != 4'b0000) chk("sel", {30'd0, sel}, m_sel);
    chk("cfg_active", {30'd0, cfg_active}, {30'd0, m_cfg});
    if (m_err) chk("err_set", {31'd0, err_timeout}, 32'd1);
    else if (m_stallrun < 12) chk("err_clear", {31'd0, err_timeout}, 32'd0);
`ifdef STRIPE_COUNT_EN
    chk("stripe_cnt", {24'd0, stripe_cnt}, m_stripes % 256);
`endif
  endtask

  task automatic send(input logic [7:0] d);
    cycle(1'b1, d, 4'b1111, 1'b0, 2'b00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_L = 1'b0; validIn = 1'b0; cfg_load = 1'b0; rdy = 4'b1111;
    @(posedge clk);
    #1;
    model_reset();
    chk("rst_outValid", {28'd0, ov3, ov2, ov1, ov0}, 32'd0);
    chk("rst_data", {d3, d2, d1, d0}, 32'd0);
    chk("rst_sel", {30'd0, sel}, 32'd0);
    chk("rst_cfg", {30'd0, cfg_active}, 32'd2);
    chk("rst_err", {31'd0, err_timeout}, 32'd0);
    @(negedge clk);
    reset_L = 1'b1;
  endtask

  initial begin
    logic [3:0] r;
    logic       v;
    reset_L = 1'b1; validIn = 1'b0; in_byte = 8'h00; rdy = 4'b1111;
    lane_cfg = 2'b00; cfg_load = 1'b0;
    model_reset();
    do_reset();

    // 4-lane stripe
    send(8'hFF); send(8'hDD); send(8'hEE); send(8'hCC);

    // reconfigure to 2 lanes mid-stripe; applies only at the boundary
    send(8'h01); send(8'h02);
    cycle(1'b0, 8'h00, 4'b1111, 1'b1, 2'b01);
    send(8'hBB); send(8'h99);
    send(8'hAA); send(8'h88); send(8'h77); send(8'h66);
    chk("t2_cfg", {30'd0, cfg_active}, 32'd1);

    // single lane
    cycle(1'b0, 8'h00, 4'b1111, 1'b1, 2'b00);
    send(8'h11); send(8'h22); send(8'h33);

    // back to 4 lanes, stall on lane 2
    cycle(1'b0, 8'h00, 4'b1111, 1'b1, 2'b10);
    send(8'h44); send(8'h55);
    for (int i = 0; i < 3; i++) cycle(1'b1, 8'hEE, 4'b1011, 1'b0, 2'b00);
    send(8'hEE);
    chk("t4_err", {31'd0, err_timeout}, 32'd0);

    // long stall on lane 1 trips the sticky watchdog
    send(8'h5A); send(8'hA5);
    for (int i = 0; i < STALL_MAX + 4; i++) cycle(1'b1, 8'h3C, 4'b1101, 1'b0, 2'b00);
    send(8'h3C); send(8'h3D);
    chk("t5_sticky", {31'd0, err_timeout}, 32'd1);
    do_reset();

    // randomized traffic and reconfiguration
    for (int i = 0; i < 400; i++) begin
      r = 4'b0000;
      for (int k = 0; k < 4; k++) r[k] = ($urandom_range(0, 4) != 0);
      v = ($urandom_range(0, 3) != 0) && (m_stallrun < 5);
      cycle(v, 8'($urandom), r, ($urandom_range(0, 19) == 0), 2'($urandom));
    end

    // reset mid-stripe, then the next byte goes to lane 0
    cycle(1'b0, 8'h00, 4'b1111, 1'b1, 2'b10);
    send(8'h10); send(8'h20); send(8'h30); send(8'h40);
    send(8'h50); send(8'h60);
    do_reset();
    send(8'h77);
    chk("t6_lane0", {28'd0, ov3, ov2, ov1, ov0}, 32'd1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
